updown_counter: RTL and testbench

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/updown_counter.sv | 126 ++++++++++++
 tb/tb_updown_counter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Modulo up/down counter with load, clear, optional saturation and a wrap/overflow indication.
// Optional snapshot register enabled by defining UPDOWN_COUNTER_CAPTURE_EN.
module updown_counter #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 64'd256,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear,
  input  logic             capture,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             overflow,
  output logic [WIDTH-1:0] captured
);

  localparam int unsigned      EXT_W  = WIDTH + 1;
  localparam logic [WIDTH:0]   LAST_C = EXT_W'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count_r;
  logic             wrap_r;
  logic             overflow_r;
  logic [WIDTH-1:0] captured_r;

  logic [WIDTH:0]   count_ext_s;
  logic [WIDTH:0]   load_ext_s;
  logic [WIDTH:0]   inc_s;
  logic [WIDTH:0]   dec_s;
  logic             at_top_s;
  logic             at_bottom_s;
  logic [WIDTH-1:0] next_count_s;
  logic             next_wrap_s;
  logic             next_overflow_s;

  // One extra bit keeps MODULUS-1 and the increment exact when MODULUS = 2^WIDTH.
  assign count_ext_s = {1'b0, count_r};
  assign load_ext_s  = {1'b0, load_value};
  assign inc_s       = count_ext_s + {{WIDTH{1'b0}}, 1'b1};
  assign dec_s       = count_ext_s - {{WIDTH{1'b0}}, 1'b1};
  assign at_top_s    = (count_ext_s == LAST_C);
  assign at_bottom_s = (count_r == {WIDTH{1'b0}});

  // Next-state selection: clear beats load beats enable.
  always_comb begin
    next_count_s    = count_r;
    next_wrap_s     = 1'b0;
    next_overflow_s = overflow_r;
    if (clear) begin
      next_count_s    = {WIDTH{1'b0}};
      next_overflow_s = 1'b0;
    end else if (load) begin
      if (load_ext_s > LAST_C) begin
        next_count_s = LAST_C[WIDTH-1:0];
      end else begin
        next_count_s = load_value;
      end
    end else if (enable) begin
      case ({up, (up ? at_top_s : at_bottom_s)})
        2'b10: next_count_s = inc_s[WIDTH-1:0];
        2'b00: next_count_s = dec_s[WIDTH-1:0];
        2'b11: begin
          next_count_s    = SATURATE ? count_r : {WIDTH{1'b0}};
          next_wrap_s     = 1'b1;
          next_overflow_s = 1'b1;
        end
        2'b01: begin
          next_count_s    = SATURATE ? count_r : LAST_C[WIDTH-1:0];
          next_wrap_s     = 1'b1;
          next_overflow_s = 1'b1;
        end
        default: begin
          next_count_s    = count_r;
          next_wrap_s     = 1'b0;
          next_overflow_s = overflow_r;
        end
      endcase
    end else begin
      next_count_s = count_r;
    end
  end

  // Counter state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r    <= {WIDTH{1'b0}};
      wrap_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      count_r    <= next_count_s;
      wrap_r     <= next_wrap_s;
      overflow_r <= next_overflow_s;
    end
  end

`ifdef UPDOWN_COUNTER_CAPTURE_EN
  // Snapshot of the pre-edge count, independent of clear/load/enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      captured_r <= {WIDTH{1'b0}};
    end else if (capture) begin
      captured_r <= count_r;
    end else begin
      captured_r <= captured_r;
    end
  end
`else
  logic capture_unused_s;
  assign capture_unused_s = capture;

  // Snapshot feature absent: register held at zero.
  always_ff @(posedge clock) begin
    captured_r <= {WIDTH{1'b0}};
  end
`endif

  assign count    = count_r;
  assign wrap     = wrap_r;
  assign overflow = overflow_r;
  assign captured = captured_r;

endmodule

// File: tb/tb_updown_counter.sv
// Randomised self-checking bench for updown_counter: three instances (mod 16 wrap,
// mod 10 saturate, mod 10 wrap) share stimulus and are compared to an integer model.
module tb_updown_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic       clear = 1'b0;
  logic       capture = 1'b0;

  logic [3:0] cnt_o [3];
  logic       wrap_o [3];
  logic       ovf_o [3];
  logic [3:0] cap_o [3];

  int total = 0;
  int bad   = 0;

  int m_mod [3] = '{16, 10, 10};
  int m_sat [3] = '{0, 1, 0};
  int m_cnt [3];
  int m_wrap [3];
  int m_ovf [3];
  int m_cap [3];

`ifdef UPDOWN_COUNTER_CAPTURE_EN
  localparam int CAP_EN = 1;
`else
  localparam int CAP_EN = 0;
`endif

  always #5 clock = ~clock;

  updown_counter #(.WIDTH(4), .MODULUS(64'd16), .SATURATE(1'b0)) dut16 (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .clear(clear), .capture(capture),
    .count(cnt_o[0]), .wrap(wrap_o[0]), .overflow(ovf_o[0]), .captured(cap_o[0]));

  updown_counter #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b1)) dut10s (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .clear(clear), .capture(capture),
    .count(cnt_o[1]), .wrap(wrap_o[1]), .overflow(ovf_o[1]), .captured(cap_o[1]));

  updown_counter #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b0)) dut10w (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .clear(clear), .capture(capture),
    .count(cnt_o[2]), .wrap(wrap_o[2]), .overflow(ovf_o[2]), .captured(cap_o[2]));

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: one clock edge for instance i from the spec's priority rules.
  task automatic model_step(input int i);
    if (reset) m_cap[i] = 0;
    else if (CAP_EN != 0 && capture) m_cap[i] = m_cnt[i];
    if (reset) begin
      m_cnt[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
    end else if (clear) begin
      m_cnt[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
    end else if (load) begin
      m_cnt[i]  = (int'(load_value) < m_mod[i]) ? int'(load_value) : m_mod[i] - 1;
      m_wrap[i] = 0;
    end else if (enable && up && m_cnt[i] == m_mod[i] - 1) begin
      if (m_sat[i] == 0) m_cnt[i] = 0;
      m_wrap[i] = 1; m_ovf[i] = 1;
    end else if (enable && !up && m_cnt[i] == 0) begin
      if (m_sat[i] == 0) m_cnt[i] = m_mod[i] - 1;
      m_wrap[i] = 1; m_ovf[i] = 1;
    end else if (enable) begin
      m_cnt[i]  = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
      m_wrap[i] = 0;
    end else begin
      m_wrap[i] = 0;
    end
  endtask

  // Apply current inputs on one edge, advance the model and compare every output.
  task automatic cycle();
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      model_step(i);
      check($sformatf("count[%0d]", i), int'(cnt_o[i]), m_cnt[i]);
      check($sformatf("wrap[%0d]", i), int'(wrap_o[i]), m_wrap[i]);
      check($sformatf("overflow[%0d]", i), int'(ovf_o[i]), m_ovf[i]);
      check($sformatf("captured[%0d]", i), int'(cap_o[i]), m_cap[i]);
    end
  endtask

  task automatic set_in(input logic rs, input logic cl, input logic ld, input logic [3:0] lv,
                        input logic en, input logic u, input logic cp);
    reset = rs; clear = cl; load = ld; load_value = lv; enable = en; up = u; capture = cp;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0; m_cap[i] = 0;
    end

    // Reset state
    set_in(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("reset_count", int'(cnt_o[0]), 0);

    // Count up 20 cycles on the mod-16 instance
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cycle();
      check("seq16_count", int'(cnt_o[0]), (k + 1) % 16);
      check("seq16_wrap", int'(wrap_o[0]), (k == 15) ? 1 : 0);
      if (k >= 15) check("seq16_ovf", int'(ovf_o[0]), 1);
    end

    // Saturation at the top of mod-10
    set_in(1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b1, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("sat_count", int'(cnt_o[1]), 9);
      check("sat_wrap", int'(wrap_o[1]), (k == 0) ? 0 : 1);
    end
    check("sat_ovf", int'(ovf_o[1]), 1);

    // Wrap down from 0 and load clamp on mod-10 wrap
    set_in(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    check("down_wrap_count", int'(cnt_o[2]), 9);
    check("down_wrap_pulse", int'(wrap_o[2]), 1);
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("down_wrap_end", int'(wrap_o[2]), 0);
    set_in(1'b0, 1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
    cycle();
    check("clamp_count", int'(cnt_o[2]), 9);
    check("clamp_count16", int'(cnt_o[0]), 12);

    // Priority: clear over load and enable
    set_in(1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    cycle();
    set_in(1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
    cycle();
    check("prio_count", int'(cnt_o[0]), 0);
    check("prio_ovf", int'(ovf_o[0]), 0);
    set_in(1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    cycle();
    check("prio_clear_load", int'(cnt_o[0]), 0);

    // Reset overrides everything mid-count with overflow set
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    cycle();
    check("pre_reset_ovf", int'(ovf_o[0]), 1);
    set_in(1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1);
    cycle();
    check("reset_over_count", int'(cnt_o[0]), 0);
    check("reset_over_ovf", int'(ovf_o[0]), 0);

    // Capture of pre-edge count
    set_in(1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    cycle();
    check("cap_value", int'(cap_o[0]), (CAP_EN != 0) ? 5 : 0);
    check("cap_count", int'(cnt_o[0]), 6);

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      set_in(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
